if_prefetch_buf: RTL and testbench
==================================

Name: if_prefetch_buf

Overview:
- Instruction-fetch prefetch buffer between the asynchronous-read instruction memory (imem) and the IF/ID boundary of flow_cpu.
- Generates sequential word addresses, reads imem one word per cycle and queues {pc, inst} pairs in a small FIFO.
- Presents queued pairs to the pipeline with a valid/ready handshake.
- Flushes and restarts on a branch/jump redirect from the pipeline.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  pipeline requests a fetch restart this cycle.
- redirect_pc  input  32  restart target; bits [1:0] are ignored and treated as 0.
- imem_addr  output  32  word-aligned fetch address, driven to imem.
- IM_R  output  1  imem read strobe.
- imem_data  input  32  imem read data, combinational from imem_addr in the same cycle.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  pipeline accepts the head entry this cycle.
- out_pc  output  32  PC of the head entry.
- out_inst  output  32  instruction of the head entry.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset, asserted asynchronously:
  - fetch_pc = RESET_PC, FIFO empty, count = 0.
  - out_valid = 0; out_pc and out_inst = 0.
  - IM_R = 0, imem_addr = RESET_PC.
- Combinational outputs:
  - imem_addr = fetch_pc.
  - IM_R = 1 when the push condition below holds, otherwise 0.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop).
  - A full FIFO accepts a push in the same cycle as a pop.
- On push:
  - Write {fetch_pc, imem_data} at the tail.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- On pop: advance the head.
- count update:
  - +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Output timing:
  - out_valid = (count != 0).
  - out_pc and out_inst come from the head entry, read combinationally from FIFO storage.
  - Latency: an instruction pushed in cycle N is visible at the outputs in cycle N+1.
- Redirect (redirect_valid = 1) has priority over everything else:
  - All entries discarded; count <= 0; no push.
  - A pop in the same cycle is ignored and has no effect.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - out_valid = 0 in the next cycle; the first redirected instruction appears 2 cycles after the redirect edge.
- Back-to-back redirects: the last one wins; fetch stays halted while redirect_valid is held high.
- Full with out_ready = 0: IM_R = 0, fetch_pc holds, entries hold, outputs stable.
- Empty with out_ready = 1: no pop occurs, and count never underflows.
- Pointers: head/tail are clog2(DEPTH) bits and wrap naturally.
- Reset mid-operation: returns to the reset state immediately; there is no partial flush ordering.
- The internal state machine is implicit, with two states:
  - FETCH: the default state.
  - HALT: entered while full with no pop, or while redirect_valid is held.
- No separate state register is required; the state is derived from count and redirect_valid.

Decomposition:
- Shared package / header:
  - PC_STEP = 4.
  - INST_NOP = 32'h0000_0000.
  - RESET_PC default.
  - clog2 function.
- Sub-module pf_fifo: synchronous FIFO with flush.
  - Ports: clk_in, reset, flush, push, wdata[63:0], pop, rdata[63:0], count.
- if_prefetch_buf holds fetch_pc, the push/pop/redirect logic and the output mapping.

Test Plan:
1. Reset release, imem returns addr ^ 32'hA5A5_0000, out_ready = 1 → four outputs in consecutive cycles:
   - out_pc = 0, 4, 8, 12.
   - out_inst = 32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C.
   - First valid one cycle after the first push.
2. out_ready = 0 from reset → count reaches 4 after 4 cycles.
   - IM_R then drops to 0 and imem_addr holds at 32'h10.
   - Raise out_ready → out_pc sequence 0, 4, 8, 12, 16 with no gaps and no duplicates.
3. Redirect_valid pulse with redirect_pc = 32'h0000_0103 while count = 3:
   - Next cycle: count = 0, out_valid = 0, imem_addr = 32'h100.
   - Following cycle: out_pc = 32'h100.
4. Full FIFO with out_ready = 1 held → push and pop in every cycle.
   - count stays at 4; fetch_pc advances by 4 each cycle.
5. redirect_pc = 32'hFFFF_FFF8, run 3 pushes → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
6. Assert reset (low) mid-stream with count = 2 → outputs go to zero immediately.
   - After release, fetch restarts at RESET_PC = 0.

Source files
------------

// File: rtl/if_prefetch_buf_pkg.sv
// Shared constants, types and helpers for the instruction-fetch prefetch buffer.
package if_prefetch_buf_pkg;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Fetch is halted when the buffer is full without a pop, or a redirect is held.
  typedef enum logic {
    StFetch = 1'b0,
    StHalt  = 1'b1
  } pf_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << r) < n) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/if_prefetch_buf_pf_fifo.sv
// pf_fifo: synchronous {pc, inst} FIFO with single-cycle flush and combinational head read.
module if_prefetch_buf_pf_fifo
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [63:0]            wdata,
  input  logic                   pop,
  output logic [63:0]            rdata,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk_in) begin
    if (push && !flush) begin
      mem_q[tail_q] <= wdata;
    end
  end

  assign rdata = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction-fetch prefetch buffer: sequential imem reads queued as {pc, inst} with redirect flush.
module if_prefetch_buf
  import if_prefetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            imem_addr,
  output logic                   IM_R,
  input  logic [31:0]            imem_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        pop, push;
  pf_state_e   state;
  logic [63:0] rdata;
  logic [1:0]  unused_rpc_lsb;

  assign unused_rpc_lsb = redirect_pc[1:0];

  always_comb begin
    pop   = out_valid & out_ready;
    state = (redirect_valid || ((count == FullCnt) && !pop)) ? StHalt : StFetch;
    // Gating with reset keeps the read strobe low while reset is held.
    push  = (state == StFetch) & reset;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_prefetch_buf_pf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .flush  (redirect_valid),
    .push   (push),
    .wdata  ({fetch_pc_q, imem_data}),
    .pop    (pop),
    .rdata  (rdata),
    .count  (count)
  );

  assign imem_addr = fetch_pc_q;
  assign IM_R      = push;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? rdata[63:32] : 32'h0;
  assign out_inst  = out_valid ? rdata[31:0]  : INST_NOP;

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf with a reference fetch model and {pc, inst} scoreboard.
module tb_if_prefetch_buf;

  logic        clk_in;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        IM_R;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  logic [63:0] sb[$];

  if_prefetch_buf #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .IM_R           (IM_R),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .count          (count)
  );

  assign imem_data = imem_addr ^ 32'hA5A5_0000;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc = 32'h0;
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model, return after the edge.
  task automatic cycle(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic m_pop, m_push;
    int   m_cnt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk_in);
    m_cnt  = sb.size();
    m_pop  = (m_cnt != 0) && rdy;
    m_push = !rv && ((m_cnt < 4) || m_pop);
    chk({tag, "_cnt"},   64'(count), 64'(m_cnt));
    chk({tag, "_valid"}, 64'(out_valid), 64'(m_cnt != 0));
    chk({tag, "_imr"},   64'(IM_R), 64'(m_push));
    chk({tag, "_addr"},  64'(imem_addr), 64'(m_pc));
    if (m_cnt != 0) begin
      chk({tag, "_head"}, {out_pc, out_inst}, sb[0]);
    end
    if (rv) begin
      sb.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        sb.push_back({m_pc, m_pc ^ 32'hA5A5_0000});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clk_in);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_cnt",   64'(count), 64'(0));
    chk("rst_imr",   64'(IM_R), 64'(0));
    chk("rst_addr",  64'(imem_addr), 64'(32'h0));
    chk("rst_pc",    64'(out_pc), 64'(0));
    chk("rst_inst",  64'(out_inst), 64'(0));
    @(posedge clk_in);
    #1;
    reset = 1'b1;

    // Streaming with out_ready high.
    for (int i = 0; i < 6; i++) cycle("t1", 1'b0, 32'h0, 1'b1);

    // Fill with out_ready low, then drain.
    do_reset();
    for (int i = 0; i < 4; i++) cycle("t2f", 1'b0, 32'h0, 1'b0);
    chk("t2_full", 64'(count), 64'(4));
    chk("t2_imr",  64'(IM_R), 64'(0));
    chk("t2_addr", 64'(imem_addr), 64'(32'h10));
    cycle("t2h", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) cycle("t2d", 1'b0, 32'h0, 1'b1);

    // Redirect at count 3; the simultaneous pop must be ignored.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("t3f", 1'b0, 32'h0, 1'b0);
    cycle("t3r", 1'b1, 32'h0000_0103, 1'b1);
    chk("t3_cnt",   64'(count), 64'(0));
    chk("t3_valid", 64'(out_valid), 64'(0));
    chk("t3_addr",  64'(imem_addr), 64'(32'h100));
    cycle("t3a", 1'b0, 32'h0, 1'b1);
    chk("t3_pc", 64'(out_pc), 64'(32'h100));
    for (int i = 0; i < 3; i++) cycle("t3b", 1'b0, 32'h0, 1'b1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) cycle("t4f", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("t4s", 1'b0, 32'h0, 1'b1);
    chk("t4_cnt",  64'(count), 64'(4));
    chk("t4_addr", 64'(imem_addr), 64'(32'h24));

    // Back-to-back redirects then wrap past 2^32.
    cycle("t5r0", 1'b1, 32'h0000_0200, 1'b1);
    cycle("t5r1", 1'b1, 32'hFFFF_FFF9, 1'b1);
    for (int i = 0; i < 3; i++) cycle("t5f", 1'b0, 32'h0, 1'b0);
    chk("t5_addr", 64'(imem_addr), 64'(32'h4));
    cycle("t5d0", 1'b0, 32'h0, 1'b1);
    cycle("t5d1", 1'b0, 32'h0, 1'b1);
    chk("t5_wrap", 64'(out_pc), 64'(32'h0));
    for (int i = 0; i < 2; i++) cycle("t5d", 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream at count 2.
    do_reset();
    for (int i = 0; i < 2; i++) cycle("t6f", 1'b0, 32'h0, 1'b0);
    chk("t6_pre", 64'(count), 64'(2));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 64'(out_valid), 64'(0));
    chk("t6_cnt",   64'(count), 64'(0));
    chk("t6_pc",    64'(out_pc), 64'(0));
    chk("t6_inst",  64'(out_inst), 64'(0));
    chk("t6_imr",   64'(IM_R), 64'(0));
    chk("t6_addr",  64'(imem_addr), 64'(0));
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle("t6r", 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
